dram_arbiter: RTL
=================

DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 SHALL take parameters:
- ADDR_W, default 16: DRAM address width.
- DATA_W, default 8: DRAM data width.
- RD_LAT, default 2: DRAM read latency in clk edges, from address registered to q valid.

REQ-002 SHALL have one clock; reset is synchronous and active-low. Ports, clock and reset first:
- clk  in  1  sole clock; all state on posedge.
- rst_n  in  1  synchronous active-low reset.
- wr_req  in  1  UART writer requests a write.
- wr_addr  in  ADDR_W  writer address.
- wr_data  in  DATA_W  writer data.
- wr_gnt  out  1  writer transfer accepted this cycle.
- proc_req  in  1  downsampling processor requests an access.
- proc_we  in  1  processor access is a write (1) or a read (0).
- proc_addr  in  ADDR_W  processor address.
- proc_wdata  in  DATA_W  processor write data.
- proc_gnt  out  1  processor transfer accepted.
- proc_rvalid  out  1  processor read data valid.
- rd_req  in  1  TX retriever requests a read.
- rd_addr  in  ADDR_W  retriever address.
- rd_gnt  out  1  retriever transfer accepted.
- rd_rvalid  out  1  retriever read data valid.
- rdata  out  DATA_W  read data, shared by both read requesters.
- ram_addr  out  ADDR_W  to DRAM address.
- ram_wdata  out  DATA_W  to DRAM data.
- ram_wren  out  1  to DRAM wren.
- ram_q  in  DATA_W  from DRAM q.

Function
REQ-003 SHALL grant at most one requester per cycle; x_gnt is combinational from the x_req inputs and the registered priority pointer; a transfer occurs on the edge where x_req and x_gnt are both high.
REQ-004 SHALL let a requester hold req high across consecutive transfers, updating addr/data on the edge its transfer completes; back-to-back grants to the same requester are legal when no other requester is waiting.
REQ-005 SHALL register ram_addr, ram_wdata and ram_wren on the transfer edge; ram_wren=1 for one cycle on writer transfers and processor transfers with proc_we=1, and 0 otherwise.
REQ-006 SHALL hold ram_addr and ram_wdata at their last values in cycles with no transfer, with ram_wren=0.
REQ-007 SHALL, for each read transfer, push an owner tag (proc or rd) into an RD_LAT-deep shift pipeline, then pulse the matching *_rvalid for one cycle with rdata=ram_q exactly RD_LAT+1 edges after the transfer edge.
REQ-008 SHALL support one read transfer per cycle with no limit on outstanding reads; rvalid pulses return in issue order.
REQ-009 SHALL drop a transfer presented by no requester; rdata holds its value when no rvalid is high.
REQ-010 SHALL, with round-robin enabled, start the priority order at the requester after the last granted one (wr→proc→rd→wr), so that any waiting requester is granted within 2 other transfers.
REQ-011 SHALL update the pointer only on a transfer edge; with no requests, the pointer holds.
REQ-012 SHALL allow simultaneous rvalid and a new grant in the same cycle; a write issued immediately after a read to the same address does not alter the data already in flight for that read.

Reset
REQ-013 SHALL, while rst_n=0 at an edge, force all *_gnt low (combinationally, whenever rst_n=0), ram_wren=0, ram_addr=0, ram_wdata=0, rdata=0, all *_rvalid=0, the tag pipeline empty, and the pointer to "last=rd" (wr highest priority).
REQ-014 SHALL discard reads in flight when reset is asserted mid-operation; no rvalid occurs for them after reset is released.

Configuration
REQ-015 SHALL, with macro ARB_ROUND_ROBIN_EN defined, arbitrate round-robin per REQ-010; without it, use fixed priority wr > proc > rd, with the pointer logic not instantiated.

Verification
REQ-016 Reset check: rst_n=0 for 3 cycles with all req=1 → all gnt=0, ram_wren=0, ram_addr=0, no rvalid.
REQ-017 Write then read: wr_req with addr 0x0010 and data 0xA5 is granted; then rd_req at 0x0010 → rd_rvalid with rdata=0xA5 exactly 3 edges after rd transfer (RD_LAT=2).
REQ-018 Round-robin: all three req held high for 6 cycles → grant sequence wr,proc,rd,wr,proc,rd and ram_wren pattern 1,proc_we,0,1,proc_we,0.
REQ-019 Fixed priority (macro undefined): wr and rd held high for 4 cycles → wr granted 4 times and rd never granted; drop wr → rd granted next cycle.
REQ-020 Interleaved reads: proc read 0x0001 and rd read 0x0002 on consecutive cycles → proc_rvalid, then rd_rvalid, on consecutive cycles with the respective stored data.
REQ-021 Reset mid-read: issue proc read, assert rst_n=0 one edge later → no proc_rvalid ever appears for that read.

Source files
------------

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares one DRAM port between a UART writer, a downsampling processor and a
// TX retriever, returning read data through a tagged pipeline. Macro ARB_ROUND_ROBIN_EN selects round-robin.
module dram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              proc_req,
  input  logic              proc_we,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  output logic              proc_gnt,
  output logic              proc_rvalid,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  logic wr_g, proc_g, rd_g;
  logic wr_xfer, proc_xfer, rd_xfer;

`ifdef ARB_ROUND_ROBIN_EN
  // last_q encodes the most recently granted requester: 0 = wr, 1 = proc, 2 = rd
  logic [1:0] last_q, last_d;

  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= 2'd2;
    else        last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    if (wr_xfer)        last_d = 2'd0;
    else if (proc_xfer) last_d = 2'd1;
    else if (rd_xfer)   last_d = 2'd2;
  end

  always_comb begin
    wr_g   = 1'b0;
    proc_g = 1'b0;
    rd_g   = 1'b0;
    if (rst_n) begin
      case (last_q)
        2'd0: begin
          if (proc_req)     proc_g = 1'b1;
          else if (rd_req)  rd_g   = 1'b1;
          else if (wr_req)  wr_g   = 1'b1;
        end
        2'd1: begin
          if (rd_req)        rd_g   = 1'b1;
          else if (wr_req)   wr_g   = 1'b1;
          else if (proc_req) proc_g = 1'b1;
        end
        default: begin
          if (wr_req)        wr_g   = 1'b1;
          else if (proc_req) proc_g = 1'b1;
          else if (rd_req)   rd_g   = 1'b1;
        end
      endcase
    end
  end
`else
  always_comb begin
    wr_g   = rst_n & wr_req;
    proc_g = rst_n & proc_req & ~wr_req;
    rd_g   = rst_n & rd_req & ~wr_req & ~proc_req;
  end
`endif

  assign wr_gnt    = wr_g;
  assign proc_gnt  = proc_g;
  assign rd_gnt    = rd_g;
  assign wr_xfer   = wr_req & wr_g;
  assign proc_xfer = proc_req & proc_g;
  assign rd_xfer   = rd_req & rd_g;

  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_wren_q, ram_wren_d;
  logic              iss_vld_q, iss_vld_d;
  logic              iss_rd_q, iss_rd_d;
  logic [RD_LAT-1:0] pipe_vld_q;
  logic [RD_LAT-1:0] pipe_rd_q;
  logic              proc_rvalid_q, proc_rvalid_d;
  logic              rd_rvalid_q, rd_rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Request register: one DRAM command per transfer edge, read ownership tagged alongside
  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_wren_d  = 1'b0;
    iss_vld_d   = 1'b0;
    iss_rd_d    = 1'b0;
    if (wr_xfer) begin
      ram_addr_d  = wr_addr;
      ram_wdata_d = wr_data;
      ram_wren_d  = 1'b1;
    end else if (proc_xfer) begin
      ram_addr_d = proc_addr;
      if (proc_we) begin
        ram_wdata_d = proc_wdata;
        ram_wren_d  = 1'b1;
      end else begin
        iss_vld_d = 1'b1;
      end
    end else if (rd_xfer) begin
      ram_addr_d = rd_addr;
      iss_vld_d  = 1'b1;
      iss_rd_d   = 1'b1;
    end
  end

  // Return stage: the tag leaving the pipeline decides which requester sees ram_q
  always_comb begin
    proc_rvalid_d = pipe_vld_q[RD_LAT-1] & ~pipe_rd_q[RD_LAT-1];
    rd_rvalid_d   = pipe_vld_q[RD_LAT-1] &  pipe_rd_q[RD_LAT-1];
    rdata_d       = pipe_vld_q[RD_LAT-1] ? ram_q : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      ram_wren_q    <= 1'b0;
      iss_vld_q     <= 1'b0;
      iss_rd_q      <= 1'b0;
      pipe_vld_q    <= '0;
      pipe_rd_q     <= '0;
      proc_rvalid_q <= 1'b0;
      rd_rvalid_q   <= 1'b0;
      rdata_q       <= '0;
    end else begin
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      ram_wren_q    <= ram_wren_d;
      iss_vld_q     <= iss_vld_d;
      iss_rd_q      <= iss_rd_d;
      pipe_vld_q[0] <= iss_vld_q;
      pipe_rd_q[0]  <= iss_rd_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_rd_q[i]  <= pipe_rd_q[i-1];
      end
      proc_rvalid_q <= proc_rvalid_d;
      rd_rvalid_q   <= rd_rvalid_d;
      rdata_q       <= rdata_d;
    end
  end

  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign ram_wren    = ram_wren_q;
  assign proc_rvalid = proc_rvalid_q;
  assign rd_rvalid   = rd_rvalid_q;
  assign rdata       = rdata_q;

endmodule
